// File: rtl/spartan_credit_tx_pkg.sv
// Shared types and defaults for the credit-based transmit side of the Spartan link.
// The credit defaults are also used by the receiver-side credit-return logic.
package spartan_credit_tx_pkg;

   localparam int DEF_CREDITS = 18;
   localparam int DEF_CNT_W   = 5;
   localparam int BUF_DEPTH   = 2;

   typedef logic [1:0] occ_t;

   typedef enum logic [1:0] {
      CR_HOLD,
      CR_DEC,
      CR_INC,
      CR_OVF
   } credit_op_t;

   // A send and a return in the same cycle cancel out; a return at full count is an overflow.
   function automatic credit_op_t credit_op(input logic fire, input logic ret, input logic at_max);
      credit_op_t op;
      op = CR_HOLD;
      if (fire && !ret)
         op = CR_DEC;
      else if (!fire && ret)
         op = at_max ? CR_OVF : CR_INC;
      return op;
   endfunction

endpackage

// File: rtl/spartan_credit_tx_if.sv
// Upstream VAL/RDY stream, link transmit side and credit status of the transmitter.
interface spartan_credit_tx_if
   import spartan_credit_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int CNT_W      = DEF_CNT_W
);
   logic [DATA_WIDTH-1:0] DIN;
   logic                  DIN_VAL;
   logic                  DIN_RDY;
   logic [DATA_WIDTH-1:0] TX_DATA;
   logic                  TX_VAL;
   logic                  CREDIT_RET;
   logic [CNT_W-1:0]      CREDIT_CNT;
   logic                  IDLE;
   logic                  CREDIT_ERR;

   modport master (
      output DIN, DIN_VAL, CREDIT_RET,
      input  DIN_RDY, TX_DATA, TX_VAL, CREDIT_CNT, IDLE, CREDIT_ERR
   );

   modport slave (
      input  DIN, DIN_VAL, CREDIT_RET,
      output DIN_RDY, TX_DATA, TX_VAL, CREDIT_CNT, IDLE, CREDIT_ERR
   );
endinterface

// File: rtl/spartan_credit_buf.sv
// Two-entry register FIFO holding words until a credit allows them onto the link.
module spartan_credit_buf
   import spartan_credit_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] DIN,
   input  logic                  WR,
   output logic [DATA_WIDTH-1:0] DOUT,
   input  logic                  RD,
   output occ_t                  OCC
);

   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic                  wr_ptr;
   logic                  rd_ptr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         OCC    <= 2'd0;
         for (int i = 0; i < BUF_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (WR) begin
            mem[wr_ptr] <= DIN;
            wr_ptr      <= ~wr_ptr;
         end
         if (RD)
            rd_ptr <= ~rd_ptr;
         // Simultaneous write and read touch different slots and leave occupancy unchanged.
         case ({WR, RD})
            2'b10:   OCC <= OCC + 2'd1;
            2'b01:   OCC <= OCC - 2'd1;
            default: OCC <= OCC;
         endcase
      end
   end

   assign DOUT = mem[rd_ptr];

endmodule

// File: rtl/spartan_credit_tx.sv
// Credit-gated transmitter: buffers upstream words and sends one per cycle while
// the far-end FIFO has a free entry, tracked by a local credit counter.
module spartan_credit_tx
   import spartan_credit_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int CREDITS    = DEF_CREDITS,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic               CLK,
   input  logic               RST,
   spartan_credit_tx_if.slave bus
);

   localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);

   logic [CNT_W-1:0]      credit_cnt;
   logic                  credit_err;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_val;
   logic [DATA_WIDTH-1:0] buf_dout;
   occ_t                  occ;
   logic                  din_rdy;
   logic                  accept;
   logic                  fire;
   logic                  at_max;
   credit_op_t            op;

   // Ready comes only from registered occupancy, so a full buffer never bypasses a same-cycle send.
   assign din_rdy = (occ != 2'd2);
   assign accept  = bus.DIN_VAL && din_rdy;
   assign fire    = (occ != 2'd0) && (credit_cnt != '0);
   assign at_max  = (credit_cnt == CREDIT_MAX);
   assign op      = credit_op(fire, bus.CREDIT_RET, at_max);

   spartan_credit_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .CLK  (CLK),
      .RST  (RST),
      .DIN  (bus.DIN),
      .WR   (accept),
      .DOUT (buf_dout),
      .RD   (fire),
      .OCC  (occ)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         tx_val     <= 1'b0;
         tx_data    <= '0;
         credit_cnt <= CREDIT_MAX;
         credit_err <= 1'b0;
      end else begin
         tx_val <= fire;
         if (fire)
            tx_data <= buf_dout;
         // A returned credit is only usable from the next cycle; the overflow case saturates.
         case (op)
            CR_DEC:  credit_cnt <= credit_cnt - CNT_W'(1);
            CR_INC:  credit_cnt <= credit_cnt + CNT_W'(1);
            CR_OVF:  credit_err <= 1'b1;
            default: credit_cnt <= credit_cnt;
         endcase
      end
   end

   assign bus.DIN_RDY    = din_rdy;
   assign bus.TX_DATA    = tx_data;
   assign bus.TX_VAL     = tx_val;
   assign bus.CREDIT_CNT = credit_cnt;
   assign bus.CREDIT_ERR = credit_err;
   assign bus.IDLE       = (occ == 2'd0) && at_max;

endmodule

// File: tb/tb_spartan_credit_tx.sv
// Directed bench for spartan_credit_tx: cycle model of occupancy/credits plus a
// scoreboard of accepted words checked against every link word.
module tb_spartan_credit_tx;
   import spartan_credit_tx_pkg::*;

   localparam int DW = 8;
   localparam int CR = 18;
   localparam int CW = 5;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   spartan_credit_tx_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

   spartan_credit_tx #(
      .DATA_WIDTH (DW),
      .CREDITS    (CR),
      .CNT_W      (CW)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int            n_tests  = 0;
   int            n_fail   = 0;
   int            tx_count = 0;
   logic [DW-1:0] sb_q[$];
   int            m_occ    = 0;
   int            m_cnt    = CR;
   bit            m_err    = 1'b0;
   bit            exp_val  = 1'b0;
   logic [DW-1:0] last_tx  = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock: update the model from the inputs, then check all outputs at the falling edge.
   task automatic step();
      bit            fire_n;
      bit            acc_n;
      logic [DW-1:0] exp_d;
      fire_n = (m_occ != 0) && (m_cnt != 0);
      acc_n  = (bus.DIN_VAL === 1'b1) && (m_occ < 2);
      @(posedge CLK);
      if (RST) begin
         m_occ   = 0;
         m_cnt   = CR;
         m_err   = 1'b0;
         exp_val = 1'b0;
         last_tx = '0;
         sb_q.delete();
      end else begin
         exp_val = fire_n;
         if (acc_n)
            sb_q.push_back(bus.DIN);
         m_occ = m_occ + int'(acc_n) - int'(fire_n);
         if (fire_n && !bus.CREDIT_RET)
            m_cnt--;
         else if (!fire_n && bus.CREDIT_RET) begin
            if (m_cnt == CR)
               m_err = 1'b1;
            else
               m_cnt++;
         end
      end
      @(negedge CLK);
      chk("tx_val", 32'(bus.TX_VAL), 32'(exp_val));
      if (bus.TX_VAL === 1'b1) begin
         tx_count++;
         chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            exp_d = sb_q.pop_front();
            chk("tx_data", 32'(bus.TX_DATA), 32'(exp_d));
            last_tx = exp_d;
         end
      end else begin
         chk("tx_hold", 32'(bus.TX_DATA), 32'(last_tx));
      end
      chk("credit_cnt", 32'(bus.CREDIT_CNT), 32'(m_cnt));
      chk("din_rdy", 32'(bus.DIN_RDY), 32'(m_occ < 2));
      chk("idle", 32'(bus.IDLE), 32'((m_occ == 0) && (m_cnt == CR)));
      chk("credit_err", 32'(bus.CREDIT_ERR), 32'(m_err));
   endtask

   task automatic send_word(input logic [DW-1:0] w);
      bus.DIN     = w;
      bus.DIN_VAL = 1'b1;
      for (int k = 0; k < 64; k++) begin
         automatic bit will = (m_occ < 2) && !RST;
         step();
         if (will) begin
            bus.DIN_VAL = 1'b0;
            return;
         end
      end
      n_tests++;
      n_fail++;
      $error("FAIL accept_timeout: word %0h not accepted within 64 cycles", w);
      bus.DIN_VAL = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.DIN        = '0;
      bus.DIN_VAL    = 1'b0;
      bus.CREDIT_RET = 1'b0;
      RST            = 1'b1;
      @(negedge CLK);
      step();
      step();
      RST = 1'b0;
      chk("rst_cnt", 32'(bus.CREDIT_CNT), 32'(CR));
      chk("rst_idle", 32'(bus.IDLE), 32'd1);
      chk("rst_tx_val", 32'(bus.TX_VAL), 32'd0);
      chk("rst_rdy", 32'(bus.DIN_RDY), 32'd1);
      chk("rst_err", 32'(bus.CREDIT_ERR), 32'd0);
      step();

      // 20 back-to-back words with no returns: 18 go out, 2 stay buffered.
      tx_count = 0;
      for (int i = 1; i <= 20; i++)
         send_word(DW'(i));
      repeat (4) step();
      chk("stream_tx_count", 32'(tx_count), 32'd18);
      chk("stream_cnt", 32'(bus.CREDIT_CNT), 32'd0);
      chk("stream_rdy", 32'(bus.DIN_RDY), 32'd0);
      chk("stream_held", 32'(sb_q.size()), 32'd2);

      // One returned credit releases the next held word a cycle later.
      bus.CREDIT_RET = 1'b1;
      step();
      chk("ret1_cnt", 32'(bus.CREDIT_CNT), 32'd1);
      chk("ret1_no_bypass", 32'(bus.TX_VAL), 32'd0);
      bus.CREDIT_RET = 1'b0;
      step();
      chk("ret1_tx_val", 32'(bus.TX_VAL), 32'd1);
      chk("ret1_tx_data", 32'(bus.TX_DATA), 32'h13);
      chk("ret1_cnt0", 32'(bus.CREDIT_CNT), 32'd0);
      chk("ret1_rdy", 32'(bus.DIN_RDY), 32'd1);

      // 19 outstanding entries after 0x14 goes out: return them all.
      bus.CREDIT_RET = 1'b1;
      repeat (19) step();
      bus.CREDIT_RET = 1'b0;
      step();
      chk("drain_cnt", 32'(bus.CREDIT_CNT), 32'(CR));
      chk("drain_idle", 32'(bus.IDLE), 32'd1);
      chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);

      // Bring the count down to 5, then run a return every cycle alongside the stream.
      for (int i = 0; i < 13; i++)
         send_word(DW'(8'h40 + i));
      repeat (3) step();
      chk("steady_pre_cnt", 32'(bus.CREDIT_CNT), 32'd5);
      bus.DIN     = 8'h80;
      bus.DIN_VAL = 1'b1;
      step();
      bus.CREDIT_RET = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         bus.DIN = DW'(8'h80 + i);
         step();
         chk("steady_cnt", 32'(bus.CREDIT_CNT), 32'd5);
         chk("steady_tx_val", 32'(bus.TX_VAL), 32'd1);
      end
      bus.DIN_VAL = 1'b0;
      step();
      bus.CREDIT_RET = 1'b0;
      step();
      chk("steady_post_cnt", 32'(bus.CREDIT_CNT), 32'd5);
      chk("steady_sb_empty", 32'(sb_q.size()), 32'd0);
      bus.CREDIT_RET = 1'b1;
      repeat (13) step();
      bus.CREDIT_RET = 1'b0;
      step();
      chk("refill_idle", 32'(bus.IDLE), 32'd1);

      // Spurious return at full count: saturate and latch the error.
      bus.CREDIT_RET = 1'b1;
      step();
      bus.CREDIT_RET = 1'b0;
      chk("ovf_err", 32'(bus.CREDIT_ERR), 32'd1);
      chk("ovf_cnt", 32'(bus.CREDIT_CNT), 32'(CR));
      repeat (3) step();
      chk("ovf_sticky", 32'(bus.CREDIT_ERR), 32'd1);
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("ovf_rst_clear", 32'(bus.CREDIT_ERR), 32'd0);
      step();

      // Reset with two words held and a return in flight: everything is discarded.
      for (int i = 0; i < 20; i++)
         send_word(DW'(8'hA0 + i));
      repeat (2) step();
      chk("mid_held", 32'(sb_q.size()), 32'd2);
      chk("mid_cnt", 32'(bus.CREDIT_CNT), 32'd0);
      RST            = 1'b1;
      bus.CREDIT_RET = 1'b1;
      bus.DIN        = 8'hEE;
      bus.DIN_VAL    = 1'b1;
      step();
      RST            = 1'b0;
      bus.CREDIT_RET = 1'b0;
      bus.DIN_VAL    = 1'b0;
      chk("mid_rst_cnt", 32'(bus.CREDIT_CNT), 32'(CR));
      chk("mid_rst_tx_val", 32'(bus.TX_VAL), 32'd0);
      chk("mid_rst_rdy", 32'(bus.DIN_RDY), 32'd1);
      chk("mid_rst_idle", 32'(bus.IDLE), 32'd1);
      tx_count = 0;
      repeat (5) step();
      chk("mid_no_resend", 32'(tx_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
